// File: rtl/edge_detect_engine.sv
// 3x3 Sobel edge-detection engine: streams a frame from a sync-read pixel RAM and emits one
// saturated gradient magnitude (or thresholded edge bit) per input pixel over valid/ready.
module edge_detect_engine #(
   parameter int unsigned IMG_W  = 64,
   parameter int unsigned IMG_H  = 64,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [PIX_W-1:0]  threshold,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pixel,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done
);

   localparam int unsigned N     = IMG_W * IMG_H;
   localparam int unsigned MAG_W = PIX_W + 3;
   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam logic [ADDR_W-1:0] LEAD      = ADDR_W'(IMG_W + 1);
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] FLUSH_IDX = ADDR_W'(N - IMG_W - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);

   typedef enum logic [2:0] {
      StIdle, StRdIssue, StRdWait, StEmit, StFlush, StDone
   } state_e;

   state_e state_q, state_d;

   logic                     mode_q;
   logic [PIX_W-1:0]         thr_q;
   logic [ADDR_W-1:0]        src_q, dst_q;
   logic [ADDR_W-1:0]        idx_q, idx_inc;
   logic [COL_W-1:0]         col_q;
   logic [ROW_W-1:0]         row_q;
   logic [ADDR_W-1:0]        rd_addr_q, out_addr_q;
   logic [PIX_W-1:0]         pix_q;

   logic [PIX_W-1:0]         lb0 [IMG_W];
   logic [PIX_W-1:0]         lb1 [IMG_W];
   logic [PIX_W-1:0]         win_q [3][3];
   logic [PIX_W-1:0]         win_n [3][3];

   logic signed [MAG_W-1:0]  gx, gy;
   logic [MAG_W-1:0]         abs_gx, abs_gy, mag;
   logic                     border;
   logic [PIX_W-1:0]         result;

   function automatic logic signed [MAG_W-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed(MAG_W'(p));
   endfunction

   assign idx_inc = idx_q + ADDR_W'(1);

   // Window [row][col]: column 2 is the incoming column (rows r-2, r-1, r at column c).
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_n[r][0] = win_q[r][1];
         win_n[r][1] = win_q[r][2];
      end
      win_n[0][2] = lb1[col_q];
      win_n[1][2] = lb0[col_q];
      win_n[2][2] = rd_data;
   end

   assign gx = (ext(win_n[0][2]) + (ext(win_n[1][2]) <<< 1) + ext(win_n[2][2]))
             - (ext(win_n[0][0]) + (ext(win_n[1][0]) <<< 1) + ext(win_n[2][0]));
   assign gy = (ext(win_n[2][0]) + (ext(win_n[2][1]) <<< 1) + ext(win_n[2][2]))
             - (ext(win_n[0][0]) + (ext(win_n[0][1]) <<< 1) + ext(win_n[0][2]));
   assign abs_gx = gx[MAG_W-1] ? -gx : gx;
   assign abs_gy = gy[MAG_W-1] ? -gy : gy;
   assign mag    = abs_gx + abs_gy;

   // Centre sits one row up and one column left of the input; columns 0/1 wrap to a border.
   assign border = (col_q < COL_W'(2)) || (row_q < ROW_W'(2));

   always_comb begin
      if (border) begin
         result = '0;
      end else if (mode_q) begin
         result = (mag >= MAG_W'(thr_q)) ? '1 : '0;
      end else if (|mag[MAG_W-1:PIX_W]) begin
         result = '1;
      end else begin
         result = mag[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StRdIssue;
         StRdIssue: state_d = StRdWait;
         StRdWait:  state_d = (idx_q < LEAD) ? StRdIssue : StEmit;
         StEmit:    if (out_ready) state_d = (idx_q == LAST) ? StFlush : StRdIssue;
         StFlush:   if (out_ready && idx_q == LAST) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         mode_q     <= 1'b0;
         thr_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         idx_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         rd_addr_q  <= '0;
         out_addr_q <= '0;
         pix_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mode_q    <= mode;
                  thr_q     <= threshold;
                  src_q     <= src_base;
                  dst_q     <= dst_base;
                  idx_q     <= '0;
                  col_q     <= '0;
                  row_q     <= '0;
                  rd_addr_q <= src_base;
               end
            end
            StRdWait: begin
               pix_q <= result;
               if (col_q == COL_LAST) begin
                  col_q <= '0;
                  row_q <= row_q + ROW_W'(1);
               end else begin
                  col_q <= col_q + COL_W'(1);
               end
               if (idx_q < LEAD) begin
                  idx_q     <= idx_inc;
                  rd_addr_q <= src_q + idx_inc;
               end else begin
                  out_addr_q <= dst_q + idx_q - LEAD;
               end
            end
            StEmit: begin
               if (out_ready) begin
                  if (idx_q == LAST) begin
                     idx_q      <= FLUSH_IDX;
                     out_addr_q <= dst_q + FLUSH_IDX;
                     pix_q      <= '0;
                  end else begin
                     idx_q     <= idx_inc;
                     rd_addr_q <= src_q + idx_inc;
                  end
               end
            end
            StFlush: begin
               if (out_ready && idx_q != LAST) begin
                  idx_q      <= idx_inc;
                  out_addr_q <= out_addr_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Line buffers and window are refilled every frame, so they carry no reset.
   always_ff @(posedge clk_50M) begin
      if (state_q == StRdWait) begin
         lb1[col_q] <= lb0[col_q];
         lb0[col_q] <= rd_data;
         win_q      <= win_n;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign out_pixel = pix_q;
   assign out_addr  = out_addr_q;
   assign out_valid = (state_q == StEmit) || (state_q == StFlush);
   assign busy      = (state_q != StIdle) && (state_q != StDone);
   assign done      = (state_q == StDone);

endmodule
